// File: rtl/poly_pkg.sv
// Shared constants and FSM state type for the streaming polynomial subtractor.
package poly_pkg;

  localparam int unsigned COEFF_W   = 16;
  localparam int unsigned LANES     = 8;
  localparam int unsigned NUM_WORDS = 32;
  localparam int unsigned CNT_W     = 5;

  localparam int KYBER_Q   = 3329;
  localparam int BARRETT_V = 20159;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/poly_barrett_lane.sv
// Single-lane registered Barrett reduction of a signed coefficient into [-1664, 1664].
module poly_barrett_lane
  import poly_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [COEFF_W-1:0] din,
  output logic [COEFF_W-1:0] dout
);

  logic signed [31:0]        r;
  logic signed [31:0]        prod;
  logic signed [31:0]        quo;
  logic signed [31:0]        t;
  logic signed [COEFF_W-1:0] res;

  // Rounded quotient estimate: (v*r + 2^25) >> 26 approximates r/q.
  always_comb begin
    r    = 32'($signed(din));
    prod = r * 32'(BARRETT_V) + (32'sd1 <<< 25);
    quo  = prod >>> 26;
    t    = quo * 32'(KYBER_Q);
    res  = COEFF_W'(r - t);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (en) begin
      dout <= res;
    end
  end

endmodule

// File: rtl/poly_sub_stream.sv
// Streams one polynomial of A and B words and emits lane-wise A - B through a 2-entry skid FIFO.
// Optional Barrett reduction stage enabled by defining POLY_SUB_BARRETT_EN.
module poly_sub_stream
  import poly_pkg::*;
(
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iStart,
  input  logic                     iValidA,
  input  logic [LANES*COEFF_W-1:0] iCoeffsA,
  input  logic                     iValidB,
  input  logic [LANES*COEFF_W-1:0] iCoeffsB,
  output logic                     oReady,
  output logic                     oValid,
  output logic [LANES*COEFF_W-1:0] oCoeffs,
  output logic                     oLast,
  input  logic                     iReady,
  output logic                     oBusy,
  output logic                     oDone
);

  localparam int unsigned      DATA_W   = LANES * COEFF_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t            state;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic              accept;
  logic              pop;
  logic              is_last;
  logic [DATA_W-1:0] diff;
  logic              push_valid;
  logic [DATA_W-1:0] push_data;
  logic              push_last;
  logic              sk_valid;
  logic [DATA_W-1:0] sk_data;
  logic              sk_last;
  logic [2:0]        occ_nxt;

  assign accept  = oReady & iValidA & iValidB;
  assign pop     = oValid & iReady;
  assign is_last = (in_cnt == LAST_IDX);

  for (genvar k = 0; k < LANES; k++) begin : g_diff
    assign diff[k*COEFF_W +: COEFF_W] =
      iCoeffsA[k*COEFF_W +: COEFF_W] + (~iCoeffsB[k*COEFF_W +: COEFF_W] + COEFF_W'(1));
  end

`ifdef POLY_SUB_BARRETT_EN
  logic              pipe_valid;
  logic              pipe_last;
  logic [DATA_W-1:0] red;

  for (genvar k = 0; k < LANES; k++) begin : g_red
    poly_barrett_lane u_lane (
      .clk   (iClk),
      .rst_n (iRst_n),
      .en    (accept),
      .din   (diff[k*COEFF_W +: COEFF_W]),
      .dout  (red[k*COEFF_W +: COEFF_W])
    );
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      pipe_valid <= 1'b0;
      pipe_last  <= 1'b0;
    end else begin
      pipe_valid <= accept;
      pipe_last  <= accept & is_last;
    end
  end

  assign push_valid = pipe_valid;
  assign push_data  = red;
  assign push_last  = pipe_last;
  // Words in flight include the reduction register so the FIFO can never overflow.
  assign occ_nxt    = 3'(oValid) + 3'(sk_valid) + 3'(pipe_valid) + 3'(accept) - 3'(pop);
`else
  assign push_valid = accept;
  assign push_data  = diff;
  assign push_last  = is_last;
  assign occ_nxt    = 3'(oValid) + 3'(sk_valid) + 3'(accept) - 3'(pop);
`endif

  // Output head register plus one skid entry; head holds while downstream stalls.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oValid   <= 1'b0;
      oCoeffs  <= '0;
      oLast    <= 1'b0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
      sk_last  <= 1'b0;
    end else if (pop) begin
      if (sk_valid) begin
        oCoeffs  <= sk_data;
        oLast    <= sk_last;
        sk_valid <= push_valid;
        if (push_valid) begin
          sk_data <= push_data;
          sk_last <= push_last;
        end
      end else begin
        oValid <= push_valid;
        oLast  <= push_valid & push_last;
        if (push_valid) begin
          oCoeffs <= push_data;
        end
      end
    end else if (push_valid) begin
      if (!oValid) begin
        oValid  <= 1'b1;
        oCoeffs <= push_data;
        oLast   <= push_last;
      end else begin
        sk_valid <= 1'b1;
        sk_data  <= push_data;
        sk_last  <= push_last;
      end
    end
  end

  // Control FSM with word counters; oReady is computed from next-cycle occupancy.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      oReady  <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (accept) in_cnt <= in_cnt + CNT_W'(1);
      if (pop) out_cnt <= out_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (iStart) begin
            state   <= RUN;
            oBusy   <= 1'b1;
            oReady  <= 1'b1;
            in_cnt  <= '0;
            out_cnt <= '0;
          end
        end
        RUN: begin
          oReady <= !(accept && is_last) && (occ_nxt < 3'd2);
          if (accept && is_last) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && out_cnt == LAST_IDX) begin
            state <= DONE;
            oDone <= 1'b1;
            oBusy <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sub_stream.sv
// Self-checking bench for poly_sub_stream: table vectors plus randomized polynomial streams.
module tb_poly_sub_stream;
  import poly_pkg::*;

  localparam int unsigned DW = LANES * COEFF_W;
`ifdef POLY_SUB_BARRETT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          iClk = 1'b0;
  logic          iRst_n, iStart, iValidA, iValidB, iReady;
  logic [DW-1:0] iCoeffsA, iCoeffsB;
  logic          oReady, oValid, oLast, oBusy, oDone;
  logic [DW-1:0] oCoeffs;

  poly_sub_stream dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iStart   (iStart),
    .iValidA  (iValidA),
    .iCoeffsA (iCoeffsA),
    .iValidB  (iValidB),
    .iCoeffsB (iCoeffsB),
    .oReady   (oReady),
    .oValid   (oValid),
    .oCoeffs  (oCoeffs),
    .oLast    (oLast),
    .iReady   (iReady),
    .oBusy    (oBusy),
    .oDone    (oDone)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t          tab[8];
  logic [DW-1:0] word_a[NUM_WORDS];
  logic [DW-1:0] word_b[NUM_WORDS];
  logic [DW-1:0] word_exp[NUM_WORDS];
  logic [DW-1:0] exp_q[$];
  logic          last_q[$];
  int            cyc_q[$];
  int            errors = 0;
  int            checks = 0;

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: exact difference modulo 2^16, optionally its centered residue mod q.
  function automatic logic [15:0] ref_lane(input logic [15:0] a, input logic [15:0] b);
    int d;
    logic signed [15:0] rs;
`ifdef POLY_SUB_BARRETT_EN
    int m;
`endif
    d  = int'(a) - int'(b);
    rs = 16'(d);
`ifdef POLY_SUB_BARRETT_EN
    m = int'(rs) % KYBER_Q;
    if (m < 0) m += KYBER_Q;
    if (m > KYBER_Q / 2) m -= KYBER_Q;
    return 16'(m);
`else
    return 16'(rs);
`endif
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*16 +: 16] = ref_lane(a[k*16 +: 16], b[k*16 +: 16]);
    return r;
  endfunction

  task automatic fill_random(input bit use_table);
    for (int w = 0; w < NUM_WORDS; w++) begin
      word_a[w]   = {$urandom(), $urandom(), $urandom(), $urandom()};
      word_b[w]   = {$urandom(), $urandom(), $urandom(), $urandom()};
      word_exp[w] = ref_word(word_a[w], word_b[w]);
    end
    if (use_table) begin
      for (int i = 0; i < 8; i++) begin
        word_a[i]   = {LANES{tab[i].a}};
        word_b[i]   = {LANES{tab[i].b}};
        word_exp[i] = {LANES{tab[i].exp}};
      end
    end
  endtask

  task automatic idle_inputs();
    iStart = 1'b0; iValidA = 1'b0; iValidB = 1'b0; iReady = 1'b1;
    iCoeffsA = '0; iCoeffsB = '0;
  endtask

  // Streams one polynomial; every cycle checks done/busy/ready, stall stability and results.
  task automatic run_poly(input string tag, input int pa, input int pb, input int pr,
                          input int stall_at, input int stall_len, input int b_hold,
                          input bit start_mid, input int rst_word);
    int widx, outstanding;
    bit done_exp, prev_stall, finished, full_rate, ina, inb, in_hs, out_hs;
    logic [DW-1:0] prev_data;
    logic prev_last;
    exp_q.delete(); last_q.delete(); cyc_q.delete();
    full_rate = (pr == 100) && (stall_len == 0);
    widx = 0; outstanding = 0; done_exp = 0; prev_stall = 0; finished = 0;
    prev_data = '0; prev_last = 1'b0;
    iStart = 1'b1;
    @(posedge iClk); @(negedge iClk);
    iStart = 1'b0;
    check1({tag, " busy_after_start"}, oBusy, 1'b1);
    check1({tag, " ready_after_start"}, oReady, 1'b1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      check1({tag, " done"}, oDone, done_exp);
      check1({tag, " busy"}, oBusy, !done_exp);
      if (done_exp) begin
        finished = 1;
        break;
      end
      if (prev_stall) begin
        check1({tag, " stall_valid"}, oValid, 1'b1);
        checkw({tag, " stall_data"}, oCoeffs, prev_data);
        check1({tag, " stall_last"}, oLast, prev_last);
      end
      check1($sformatf("%s ready w%0d occ%0d", tag, widx, outstanding), oReady,
             (widx < int'(NUM_WORDS)) && (outstanding < 2));
      if (rst_word >= 0 && widx == rst_word) begin
        idle_inputs();
        iRst_n = 1'b0;
        @(posedge iClk); @(negedge iClk);
        check1({tag, " rst_ready"}, oReady, 1'b0);
        check1({tag, " rst_valid"}, oValid, 1'b0);
        checkw({tag, " rst_coeffs"}, oCoeffs, '0);
        check1({tag, " rst_last"}, oLast, 1'b0);
        check1({tag, " rst_busy"}, oBusy, 1'b0);
        check1({tag, " rst_done"}, oDone, 1'b0);
        iRst_n = 1'b1;
        repeat (3) begin
          @(posedge iClk); @(negedge iClk);
          check1({tag, " post_rst_done"}, oDone, 1'b0);
          check1({tag, " post_rst_busy"}, oBusy, 1'b0);
          check1({tag, " post_rst_valid"}, oValid, 1'b0);
        end
        return;
      end
      ina = (widx < int'(NUM_WORDS)) && (int'($urandom_range(99)) < pa);
      inb = (widx < int'(NUM_WORDS)) && (int'($urandom_range(99)) < pb);
      if (cyc < b_hold) begin
        ina = (widx < int'(NUM_WORDS));
        inb = 1'b0;
      end
      iValidA  = ina;
      iValidB  = inb;
      iCoeffsA = (widx < int'(NUM_WORDS)) ? word_a[widx] : {$urandom(), $urandom(), $urandom(), $urandom()};
      iCoeffsB = (widx < int'(NUM_WORDS)) ? word_b[widx] : {$urandom(), $urandom(), $urandom(), $urandom()};
      if (cyc >= stall_at && cyc < stall_at + stall_len) iReady = 1'b0;
      else iReady = (int'($urandom_range(99)) < pr);
      iStart = start_mid && (cyc == 5);
      in_hs  = oReady && ina && inb;
      out_hs = oValid && iReady;
      done_exp = 0;
      if (out_hs) begin
        if (exp_q.size() == 0) begin
          checkw({tag, " spurious_word"}, oCoeffs, 'x);
        end else begin
          checkw($sformatf("%s word%0d", tag, int'(NUM_WORDS) - outstanding - (int'(NUM_WORDS) - widx)),
                 oCoeffs, exp_q[0]);
          check1({tag, " last"}, oLast, last_q[0]);
          if (full_rate) checki({tag, " latency"}, cyc - cyc_q[0], LAT);
          done_exp = last_q[0];
          void'(exp_q.pop_front()); void'(last_q.pop_front()); void'(cyc_q.pop_front());
          outstanding--;
        end
      end
      if (in_hs) begin
        exp_q.push_back(word_exp[widx]);
        last_q.push_back(widx == int'(NUM_WORDS) - 1);
        cyc_q.push_back(cyc);
        widx++;
        outstanding++;
      end
      if (cyc < b_hold) checki({tag, " hold_no_consume"}, widx, 0);
      prev_stall = oValid && !iReady;
      prev_data  = oCoeffs;
      prev_last  = oLast;
      @(posedge iClk); @(negedge iClk);
    end
    idle_inputs();
    if (!finished) checki({tag, " timeout_no_done"}, 0, 1);
    checki({tag, " words_in"}, widx, int'(NUM_WORDS));
    checki({tag, " words_left"}, exp_q.size(), 0);
    @(posedge iClk); @(negedge iClk);
    check1({tag, " done_one_cycle"}, oDone, 1'b0);
    check1({tag, " idle_busy"}, oBusy, 1'b0);
    check1({tag, " idle_ready"}, oReady, 1'b0);
  endtask

  initial begin
`ifdef POLY_SUB_BARRETT_EN
    tab[0] = '{16'h0005, 16'h0003, 16'h0002};
    tab[1] = '{16'h0000, 16'h0001, 16'hFFFF};
    tab[2] = '{16'h7FFF, 16'h8000, 16'hFFFF};
    tab[3] = '{16'h0D01, 16'h0000, 16'h0000};
    tab[4] = '{16'h8000, 16'h0001, 16'hFDF5};
    tab[5] = '{16'h0680, 16'h0000, 16'h0680};
    tab[6] = '{16'h0681, 16'h0000, 16'hF980};
    tab[7] = '{16'h1234, 16'h1234, 16'h0000};
`else
    tab[0] = '{16'h0005, 16'h0003, 16'h0002};
    tab[1] = '{16'h0000, 16'h0001, 16'hFFFF};
    tab[2] = '{16'h7FFF, 16'h8000, 16'hFFFF};
    tab[3] = '{16'h8000, 16'h0001, 16'h7FFF};
    tab[4] = '{16'h1234, 16'h1234, 16'h0000};
    tab[5] = '{16'h0001, 16'hFFFF, 16'h0002};
    tab[6] = '{16'h0000, 16'h8000, 16'h8000};
    tab[7] = '{16'h0680, 16'h0000, 16'h0680};
`endif
    idle_inputs();
    iRst_n = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    check1("reset ready", oReady, 1'b0);
    check1("reset valid", oValid, 1'b0);
    checkw("reset coeffs", oCoeffs, '0);
    check1("reset last", oLast, 1'b0);
    check1("reset busy", oBusy, 1'b0);
    check1("reset done", oDone, 1'b0);
    iRst_n = 1'b1;
    @(posedge iClk); @(negedge iClk);

    fill_random(1'b1);
    run_poly("table_full_rate", 100, 100, 100, 0, 0, 0, 1'b0, -1);
    fill_random(1'b0);
    run_poly("random_flow", 70, 70, 60, 0, 0, 0, 1'b0, -1);
    fill_random(1'b1);
    run_poly("stall_hold_start", 100, 100, 100, 8, 5, 3, 1'b1, -1);
    fill_random(1'b0);
    run_poly("reset_mid", 80, 80, 80, 0, 0, 0, 1'b0, 10);
    fill_random(1'b0);
    run_poly("after_reset", 100, 100, 100, 0, 0, 0, 1'b0, -1);
    fill_random(1'b0);
    run_poly("random_tail", 60, 90, 50, 0, 0, 0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
